// File: rtl/bitcoin_miner_param.sv
// SHA-256d nonce hasher: reads a 19-word header, computes the midstate once, then hashes
// NUM_NONCES nonces one round per cycle, dumping every H0 or stopping at the first H0 below target.
module bitcoin_miner_param #(
    parameter int NUM_NONCES = 16,
    parameter int CNT_W      = $clog2(NUM_NONCES) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] nonce_base,
    input  logic [31:0] target,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // The write counter also walks one prefetch and one closing cycle, so it needs room for count+1.
    localparam int WR_W  = (CNT_W < 2) ? 2 : CNT_W;
    localparam int IDX_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(NUM_NONCES - 1);

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV_TAB [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_MIDSTATE, S_NONCE_SETUP, S_BLK2, S_BLK3, S_WRITE
    } state_t;

    state_t            state_reg;
    logic              mode_reg;
    logic [31:0]       nonce_base_reg;
    logic [31:0]       target_reg;
    logic [15:0]       msg_addr_reg;
    logic [15:0]       out_addr_reg;
    logic [4:0]        rd_cnt_reg;
    logic [5:0]        round_reg;
    logic [CNT_W-1:0]  n_cnt_reg;
    logic [WR_W-1:0]   wr_cnt_reg;
    logic              found_reg;
    logic [31:0]       nonce_reg;
    logic [31:0]       win_nonce_reg;
    logic [31:0]       res_rd_reg;

    logic [31:0] hdr_reg [0:18];
    logic [31:0] w_reg   [0:15];
    logic [31:0] st_reg  [0:7];
    logic [31:0] mid_reg [0:7];
    logic [31:0] res_mem [0:NUM_NONCES-1];

    logic [31:0] st_next      [0:7];
    logic [31:0] w_next       [0:15];
    logic [31:0] dig_mid_next [0:7];
    logic [31:0] dig_iv_next  [0:7];
    logic [31:0] big_s0, big_s1, ch, maj, t1, t2, w_new;
    logic [31:0] nonce_next;
    logic [WR_W-1:0] wr_total;
    logic        res_we;
    logic        hit;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign mem_clk = clk;

    always_comb begin
        big_s1 = rotr(st_reg[4], 6) ^ rotr(st_reg[4], 11) ^ rotr(st_reg[4], 25);
        ch     = (st_reg[4] & st_reg[5]) ^ (~st_reg[4] & st_reg[6]);
        t1     = st_reg[7] + big_s1 + ch + K_TAB[round_reg] + w_reg[0];
        big_s0 = rotr(st_reg[0], 2) ^ rotr(st_reg[0], 13) ^ rotr(st_reg[0], 22);
        maj    = (st_reg[0] & st_reg[1]) ^ (st_reg[0] & st_reg[2]) ^ (st_reg[1] & st_reg[2]);
        t2     = big_s0 + maj;
        st_next[0] = t1 + t2;
        st_next[1] = st_reg[0];
        st_next[2] = st_reg[1];
        st_next[3] = st_reg[2];
        st_next[4] = st_reg[3] + t1;
        st_next[5] = st_reg[4];
        st_next[6] = st_reg[5];
        st_next[7] = st_reg[6];
        // Window holds W[t..t+15]; the new tail is W[t+16].
        w_new = (rotr(w_reg[14], 17) ^ rotr(w_reg[14], 19) ^ (w_reg[14] >> 10)) + w_reg[9]
              + (rotr(w_reg[1], 7) ^ rotr(w_reg[1], 18) ^ (w_reg[1] >> 3)) + w_reg[0];
    end

    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_win
            assign w_next[gi] = w_reg[gi + 1];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_dig
            assign dig_mid_next[gi] = mid_reg[gi] + st_next[gi];
            assign dig_iv_next[gi]  = IV_TAB[gi] + st_next[gi];
        end
    endgenerate
    assign w_next[15] = w_new;

    assign nonce_next = nonce_base_reg + 32'(n_cnt_reg);
    assign wr_total   = mode_reg ? WR_W'(2) : WR_W'(NUM_NONCES);
    assign res_we     = (state_reg == S_BLK3) && (round_reg == 6'd63) && !mode_reg;
    assign hit        = mode_reg && (dig_iv_next[0] < target_reg);

    always_ff @(posedge clk) begin
        if (res_we) res_mem[n_cnt_reg[IDX_W-1:0]] <= dig_iv_next[0];
        res_rd_reg <= res_mem[wr_cnt_reg[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            done           <= 1'b1;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 32'd0;
            mode_reg       <= 1'b0;
            nonce_base_reg <= 32'd0;
            target_reg     <= 32'd0;
            msg_addr_reg   <= 16'd0;
            out_addr_reg   <= 16'd0;
            rd_cnt_reg     <= 5'd0;
            round_reg      <= 6'd0;
            n_cnt_reg      <= '0;
            wr_cnt_reg     <= '0;
            found_reg      <= 1'b0;
            nonce_reg      <= 32'd0;
            win_nonce_reg  <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    mem_we <= 1'b0;
                    if (start) begin
                        mode_reg       <= mode;
                        nonce_base_reg <= nonce_base;
                        target_reg     <= target;
                        msg_addr_reg   <= message_addr;
                        out_addr_reg   <= output_addr;
                        mem_addr       <= message_addr;
                        rd_cnt_reg     <= 5'd0;
                        n_cnt_reg      <= '0;
                        wr_cnt_reg     <= '0;
                        found_reg      <= 1'b0;
                        done           <= 1'b0;
                        state_reg      <= S_READ;
                    end
                end
                S_READ: begin
                    // Data for the address shown last cycle arrives now.
                    if (rd_cnt_reg != 5'd0) hdr_reg[rd_cnt_reg - 5'd1] <= mem_read_data;
                    if (rd_cnt_reg < 5'd18) mem_addr <= msg_addr_reg + 16'(rd_cnt_reg) + 16'd1;
                    if (rd_cnt_reg == 5'd19) begin
                        for (int i = 0; i < 16; i++) w_reg[i] <= hdr_reg[i];
                        for (int i = 0; i < 8; i++) st_reg[i] <= IV_TAB[i];
                        round_reg <= 6'd0;
                        state_reg <= S_MIDSTATE;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + 5'd1;
                    end
                end
                S_MIDSTATE: begin
                    st_reg    <= st_next;
                    w_reg     <= w_next;
                    round_reg <= round_reg + 6'd1;
                    if (round_reg == 6'd63) begin
                        mid_reg   <= dig_iv_next;
                        state_reg <= S_NONCE_SETUP;
                    end
                end
                S_NONCE_SETUP: begin
                    nonce_reg <= nonce_next;
                    w_reg[0]  <= hdr_reg[16];
                    w_reg[1]  <= hdr_reg[17];
                    w_reg[2]  <= hdr_reg[18];
                    w_reg[3]  <= nonce_next;
                    w_reg[4]  <= 32'h80000000;
                    for (int i = 5; i < 15; i++) w_reg[i] <= 32'd0;
                    w_reg[15] <= 32'd640;
                    st_reg    <= mid_reg;
                    round_reg <= 6'd0;
                    state_reg <= S_BLK2;
                end
                S_BLK2: begin
                    round_reg <= round_reg + 6'd1;
                    if (round_reg == 6'd63) begin
                        for (int i = 0; i < 8; i++) w_reg[i] <= dig_mid_next[i];
                        w_reg[8] <= 32'h80000000;
                        for (int i = 9; i < 15; i++) w_reg[i] <= 32'd0;
                        w_reg[15] <= 32'd256;
                        for (int i = 0; i < 8; i++) st_reg[i] <= IV_TAB[i];
                        state_reg <= S_BLK3;
                    end else begin
                        st_reg <= st_next;
                        w_reg  <= w_next;
                    end
                end
                S_BLK3: begin
                    st_reg    <= st_next;
                    w_reg     <= w_next;
                    round_reg <= round_reg + 6'd1;
                    if (round_reg == 6'd63) begin
                        if (hit || n_cnt_reg == LAST_N) begin
                            found_reg     <= hit;
                            win_nonce_reg <= nonce_reg;
                            wr_cnt_reg    <= '0;
                            state_reg     <= S_WRITE;
                        end else begin
                            n_cnt_reg <= n_cnt_reg + CNT_W'(1);
                            state_reg <= S_NONCE_SETUP;
                        end
                    end
                end
                S_WRITE: begin
                    // Cycle 0 primes the result RAM read; the final cycle closes the job.
                    wr_cnt_reg <= wr_cnt_reg + WR_W'(1);
                    if (wr_cnt_reg == wr_total + WR_W'(1)) begin
                        mem_we    <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_IDLE;
                    end else if (wr_cnt_reg != '0) begin
                        mem_we   <= 1'b1;
                        mem_addr <= out_addr_reg + 16'(wr_cnt_reg) - 16'd1;
                        if (mode_reg)
                            mem_write_data <= (wr_cnt_reg == WR_W'(1)) ? {31'd0, found_reg} : win_nonce_reg;
                        else
                            mem_write_data <= res_rd_reg;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin_miner_param.sv
// Bench for bitcoin_miner_param: four instances (16/4/1/256 nonces) on a shared header memory,
// checked against a straightforward full-schedule SHA-256 model.
module tb_bitcoin_miner_param;

    typedef logic [31:0] w32;

    localparam int NN [4] = '{16, 4, 1, 256};
    localparam logic [255:0] IV_M = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam w32 KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        string name;
        int    inst;
        logic  mode;
        w32    nb;
        w32    tg;
        int    n_wr;
        w32    exp_found;
        w32    exp_nonce;
        int    max_cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    w32          nonce_base, target;
    logic [15:0] message_addr, output_addr;
    logic        start_v    [4];
    logic        done_v     [4];
    logic        mem_clk_v  [4];
    logic        mem_we_v   [4];
    logic [15:0] mem_addr_v [4];
    w32          mem_wd_v   [4];
    w32          mem_rd_v   [4];

    w32          mem [0:65535];
    logic [15:0] wlog_addr [$];
    w32          wlog_data [$];
    int          wlog_inst [$];

    w32           hdr_tb [19];
    logic [255:0] model_mid;
    int           n_cmp = 0;
    int           n_bad = 0;
    vec_t         vecs [8];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            bitcoin_miner_param #(.NUM_NONCES(NN[gi])) dut (
                .clk            (clk),
                .reset          (reset),
                .start          (start_v[gi]),
                .mode           (mode),
                .nonce_base     (nonce_base),
                .target         (target),
                .message_addr   (message_addr),
                .output_addr    (output_addr),
                .done           (done_v[gi]),
                .mem_clk        (mem_clk_v[gi]),
                .mem_we         (mem_we_v[gi]),
                .mem_addr       (mem_addr_v[gi]),
                .mem_write_data (mem_wd_v[gi]),
                .mem_read_data  (mem_rd_v[gi])
            );
        end
    endgenerate

    // One-cycle-latency read port per instance; writes are logged, not stored.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            mem_rd_v[k] <= mem[mem_addr_v[k]];
            if (mem_we_v[k] === 1'b1) begin
                wlog_addr.push_back(mem_addr_v[k]);
                wlog_data.push_back(mem_wd_v[k]);
                wlog_inst.push_back(k);
            end
        end
    end

    function automatic w32 rr(input w32 x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        w32 w [64];
        w32 hv [8];
        w32 a, b, c, d, e, f, g, h, s1, s0;
        for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32 * i -: 32];
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int i = 0; i < 64; i++) begin
            s1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
            s0 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + s1; d = c; c = b; b = a; a = s1 + s0;
        end
        return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    endfunction

    function automatic w32 model_h0(input w32 nonce);
        logic [255:0] d2, d3;
        d2 = compress(model_mid, {hdr_tb[16], hdr_tb[17], hdr_tb[18], nonce, 32'h80000000, 320'h0, 32'd640});
        d3 = compress(IV_M, {d2, 32'h80000000, 192'h0, 32'd256});
        return d3[255:224];
    endfunction

    task automatic search_model(input int n, input w32 nb, input w32 tg, output w32 found, output w32 nonce);
        found = 32'd0;
        nonce = nb + w32'(n - 1);
        for (int i = 0; i < n; i++) begin
            if (model_h0(nb + w32'(i)) < tg) begin
                found = 32'd1;
                nonce = nb + w32'(i);
                break;
            end
        end
    endtask

    task automatic chk(input string nm, input w32 act, input w32 exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic start_job(input int k, input logic m, input w32 nb, input w32 tg);
        mode = m; nonce_base = nb; target = tg;
        message_addr = 16'h0000; output_addr = 16'h0100;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int k, input int budget, output int cyc);
        cyc = 0;
        while (done_v[k] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (done_v[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", nm, done_v[k], cyc);
        end
    endtask

    task automatic check_writes(input vec_t v, input int log_start);
        int nw;
        w32 exp_d;
        nw = wlog_addr.size() - log_start;
        chk($sformatf("%s nwrites", v.name), w32'(nw), w32'(v.n_wr));
        for (int i = 0; i < nw && i < v.n_wr; i++) begin
            if (v.mode) exp_d = (i == 0) ? v.exp_found : v.exp_nonce;
            else        exp_d = model_h0(v.nb + w32'(i));
            chk($sformatf("%s w%0d addr", v.name, i), {16'd0, wlog_addr[log_start + i]}, 32'h0100 + w32'(i));
            chk($sformatf("%s w%0d data", v.name, i), wlog_data[log_start + i], exp_d);
            chk($sformatf("%s w%0d inst", v.name, i), w32'(wlog_inst[log_start + i]), w32'(v.inst));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int ls, cyc;
        ls = wlog_addr.size();
        start_job(v.inst, v.mode, v.nb, v.tg);
        chk($sformatf("%s busy", v.name), {31'd0, done_v[v.inst]}, 32'd0);
        wait_done(v.name, v.inst, NN[v.inst] * 140 + 500, cyc);
        if (v.max_cyc > 0) begin
            n_cmp++;
            if (cyc > v.max_cyc) begin
                n_bad++;
                $display("FAIL %s latency: got %0d cycles, required <= %0d", v.name, cyc, v.max_cyc);
            end else begin
                $display("ok   %s latency: %0d cycles", v.name, cyc);
            end
        end
        check_writes(v, ls);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] hb;
        logic [255:0] abc;
        w32 f, nn, tg4;
        int ls, cyc;
        vec_t pv;

        reset = 1'b1; mode = 1'b0; nonce_base = 32'd0; target = 32'd0;
        message_addr = 16'd0; output_addr = 16'h0100;
        for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
        for (int i = 0; i < 19; i++) begin
            hdr_tb[i] = 32'h01000000 ^ (w32'(i + 1) * 32'h9e3779b9);
            mem[i] = hdr_tb[i];
        end
        for (int i = 0; i < 16; i++) hb[511 - 32 * i -: 32] = hdr_tb[i];
        model_mid = compress(IV_M, hb);
        for (int i = 0; i < 8; i++) model_mid[255 - 32 * i -: 32] = model_mid[255 - 32 * i -: 32];

        // Model sanity against the published SHA-256("abc") digest.
        abc = compress(IV_M, {32'h61626380, 448'h0, 32'h18});
        chk("model abc h0", abc[255:224], 32'hba7816bf);
        chk("model abc h7", abc[31:0], 32'hf20015ad);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset done%0d", k), {31'd0, done_v[k]}, 32'd1);
            chk($sformatf("reset we%0d", k), {31'd0, mem_we_v[k]}, 32'd0);
            chk($sformatf("reset addr%0d", k), {16'd0, mem_addr_v[k]}, 32'd0);
            chk($sformatf("reset wdata%0d", k), mem_wd_v[k], 32'd0);
        end

        tg4 = model_h0(32'd3);
        vecs[0] = '{"dump16",      0, 1'b0, 32'h00000000, 32'h0,        16,  0, 0, 0};
        vecs[1] = '{"srch_hit_ff", 0, 1'b1, 32'h00000005, 32'hffffffff, 2,   0, 0, 3 * 66 + 25};
        vecs[2] = '{"srch_miss_0", 0, 1'b1, 32'h00000064, 32'h0,        2,   0, 0, 0};
        vecs[3] = '{"dump4_wrap",  1, 1'b0, 32'hfffffffe, 32'h0,        4,   0, 0, 0};
        vecs[4] = '{"srch_eq_tgt", 0, 1'b1, 32'h00000000, tg4,          2,   0, 0, 0};
        vecs[5] = '{"dump1",       2, 1'b0, 32'h12345678, 32'h0,        1,   0, 0, 0};
        vecs[6] = '{"srch1_miss",  2, 1'b1, 32'h00000007, 32'h0,        2,   0, 0, 0};
        vecs[7] = '{"dump256",     3, 1'b0, 32'h00000000, 32'h0,        256, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].mode) begin
                search_model(NN[vecs[i].inst], vecs[i].nb, vecs[i].tg, f, nn);
                vecs[i].exp_found = f;
                vecs[i].exp_nonce = nn;
            end
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset 100 cycles into a dump job: abort with no writes, then a clean rerun.
        ls = wlog_addr.size();
        start_job(0, 1'b0, 32'd0, 32'd0);
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort we", {31'd0, mem_we_v[0]}, 32'd0);
        chk("abort done", {31'd0, done_v[0]}, 32'd1);
        repeat (2500) @(negedge clk);
        chk("abort nwrites", w32'(wlog_addr.size() - ls), 32'd0);
        chk("abort idle", {31'd0, done_v[0]}, 32'd1);
        run_vec(vecs[0]);

        // start pulsed twice mid-job with different settings must be ignored.
        pv = '{"pulse_ign", 1, 1'b0, 32'h00000010, 32'h0, 4, 0, 0, 0};
        ls = wlog_addr.size();
        start_job(1, 1'b0, 32'h10, 32'h0);
        repeat (50) @(negedge clk);
        mode = 1'b1; nonce_base = 32'hdead0000; target = 32'hffffffff;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (300) @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        chk("pulse busy", {31'd0, done_v[1]}, 32'd0);
        wait_done("pulse_ign", 1, 1200, cyc);
        check_writes(pv, ls);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
